// File: rtl/timer_ctrl.sv
// rtl/timer_ctrl.sv - timer sequencing controller: prescaler, counter enable/clear, sticky irq/ovf.
module timer_ctrl #(
    parameter int PRESC_W = 8
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               stop,
    input  logic               mode,
    input  logic [PRESC_W-1:0] presc,
    input  logic               irq_ack,
    input  logic               cnt_tc,
    output logic               cnt_en,
    output logic               cnt_clr,
    output logic               busy,
    output logic               irq,
    output logic               ovf,
    output logic [7:0]         evt_cnt
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_CLEAR = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;

    localparam logic [PRESC_W-1:0] PSC_ONE = {{(PRESC_W-1){1'b0}}, 1'b1};

    logic [1:0]         state;
    logic [1:0]         state_n;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] psc;
    logic [PRESC_W-1:0] psc_n;
    logic               mode_q;
    logic               irq_q;
    logic               ovf_q;
    logic [7:0]         evt_q;
    logic               tick;
    logic               evt;
    logic               accept_start;

    assign tick         = (state == ST_RUN) && (psc == presc_q);
    assign evt          = tick && cnt_tc;
    assign accept_start = start && !stop;

    // Commands override whatever the current state would do next.
    always_comb begin
        state_n = state;
        psc_n   = psc;
        case (state)
            ST_CLEAR: begin
                state_n = ST_RUN;
                psc_n   = '0;
            end
            ST_RUN: begin
                psc_n = tick ? '0 : (psc + PSC_ONE);
                if (evt && !mode_q) begin
                    state_n = ST_IDLE;
                    psc_n   = '0;
                end
            end
            default: begin
                state_n = ST_IDLE;
                psc_n   = '0;
            end
        endcase
        if (stop) begin
            state_n = ST_IDLE;
            psc_n   = '0;
        end else if (start) begin
            state_n = ST_CLEAR;
            psc_n   = '0;
        end
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state   <= ST_IDLE;
            psc     <= '0;
            presc_q <= '0;
            mode_q  <= 1'b0;
        end else begin
            state <= state_n;
            psc   <= psc_n;
            if (accept_start) begin
                presc_q <= presc;
                mode_q  <= mode;
            end
        end
    end

    // Events are recorded even when stop lands in the same cycle; start wins over ovf/evt_cnt.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            irq_q <= 1'b0;
            ovf_q <= 1'b0;
            evt_q <= 8'd0;
        end else begin
            if (evt) begin
                irq_q <= 1'b1;
            end else if (irq_ack) begin
                irq_q <= 1'b0;
            end
            if (accept_start) begin
                ovf_q <= 1'b0;
            end else if (evt && irq_q && !irq_ack) begin
                ovf_q <= 1'b1;
            end
            if (accept_start) begin
                evt_q <= 8'd0;
            end else if (evt && (evt_q != 8'hFF)) begin
                evt_q <= evt_q + 8'd1;
            end
        end
    end

    assign cnt_clr = (state == ST_CLEAR);
    assign cnt_en  = tick;
    assign busy    = (state != ST_IDLE);
    assign irq     = irq_q;
    assign ovf     = ovf_q;
    assign evt_cnt = evt_q;

endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the 8-bit timer counter. It runs a programmable prescaler and drives the counter's count-enable and synchronous clear. It watches the counter's terminal count and raises a sticky interrupt with an acknowledge handshake. It sits between the register/command interface and the counter datapath, and supports one-shot and periodic modes.

## Interface
- Parameters
  - PRESC_W, default 8: prescaler width. Divide ratio is presc+1, from 1 to 2^PRESC_W.
- Ports
  - clk  in  1  single timing clock; all state updates on the rising edge.
  - clr  in  1  reset; asynchronous, active-low.
  - start  in  1  one-cycle command: (re)start the timer.
  - stop  in  1  one-cycle command: halt the timer; has priority over start.
  - mode  in  1  0 = one-shot, 1 = periodic; sampled when start is accepted.
  - presc  in  PRESC_W  divide ratio minus 1; sampled when start is accepted.
  - irq_ack  in  1  clears irq.
  - cnt_tc  in  1  terminal count from the counter; high while counter = 8'hFF.
  - cnt_en  out  1  count-enable to the counter; one-cycle pulse per prescaled tick.
  - cnt_clr  out  1  synchronous clear to the counter, active-high, one cycle.
  - busy  out  1  high in CLEAR and RUN.
  - irq  out  1  sticky terminal-count event flag.
  - ovf  out  1  sticky flag: an event occurred while irq was already set.
  - evt_cnt  out  8  number of events since the last start; saturates at 255.

## Operation
- States: IDLE, CLEAR, RUN. The state, the latched presc_q and mode_q, the prescaler psc, irq, ovf and evt_cnt are all registers.
- All outputs are decoded from registers only; there are no combinational paths from inputs to outputs.
  - cnt_clr = (state == CLEAR).
  - cnt_en = (state == RUN) && (psc == presc_q).
  - busy = (state != IDLE).
- Reset (clr low, asynchronous): state = IDLE, psc = 0, presc_q = 0, mode_q = 0, irq = 0, ovf = 0, evt_cnt = 0. All outputs are 0.
- Command priority, any state:
  - If stop is high, go to IDLE next cycle, regardless of start.
  - Otherwise, if start is high, latch presc and mode, clear ovf and evt_cnt, and go to CLEAR. irq is not touched by start.
- CLEAR: cnt_clr is high for this one cycle; psc is set to 0. Next state is RUN unless a command intervenes.
- RUN, per cycle:
  - If psc == presc_q, set psc to 0 (cnt_en is high this cycle). Otherwise increment psc.
- Event: cnt_en && cnt_tc in the same cycle. On an event:
  - irq is set.
  - If irq was already 1 and irq_ack is low, ovf is set.
  - evt_cnt increments, saturating at 8'hFF.
  - If mode_q == 0, go to IDLE. If mode_q == 1, stay in RUN. The prescaler continues without a gap.
- irq_ack clears irq next cycle. If irq_ack and an event occur in the same cycle, irq stays 1 and ovf is not set.
- In IDLE, psc holds at 0 and cnt_en stays 0. irq, ovf and evt_cnt hold their values.
- An event with stop in the same cycle: the event is still recorded (irq and evt_cnt update), and the next state is IDLE.

## Timing
- start sampled at edge k: CLEAR during cycle k+1, RUN from cycle k+2.
- First cnt_en falls in cycle k+2+presc.
- cnt_en period in RUN is presc+1 cycles. With presc = 0, cnt_en is high every RUN cycle.
- With the counter cleared to 0, the first event is the 256th cnt_en pulse, at cycle k+2+256·(presc+1)−1.
- Periodic events are spaced exactly 256·(presc+1) cycles apart.
- Event in cycle c:
  - irq, ovf and evt_cnt update at edge c+1.
  - One-shot: busy falls at c+1.
- stop sampled at edge s: cnt_en and busy are 0 from cycle s+1.
- Restart (start while in RUN): exactly one cnt_clr cycle, then the prescaler phase restarts from 0.
- Latency from any command to its effect on the outputs is one clock.

## Test plan
Bench model of the counter: 8-bit binary up-counter with cnt_clr and cnt_en, and cnt_tc = (out == 8'hFF).
- Reset checks:
  - Assert clr low mid-RUN, with irq = 1 and evt_cnt = 3 → all outputs are 0 immediately, without waiting for a clk edge.
  - After clr rises, the block stays in IDLE with no cnt_en.
- One-shot, presc = 0, start at cycle 10 → the following all hold:
  - cnt_clr is high in cycle 11.
  - cnt_en is high in cycles 12 through 267.
  - The event falls in cycle 267; irq = 1 and busy = 0 from cycle 268.
  - evt_cnt = 1.
- Periodic, presc = 3:
  - cnt_en pulses every 4 cycles.
  - Events are 1024 cycles apart.
  - With no irq_ack, ovf = 1 after the second event; evt_cnt counts 1, 2, 3.
- irq_ack coincident with the second periodic event → irq stays 1 and ovf stays 0.
- stop and start asserted together during RUN → IDLE next cycle, no cnt_clr pulse, presc_q unchanged.
- Restart with start at psc = 2 of 5 (presc = 5) → cnt_clr for one cycle, then psc begins again at 0; ovf and evt_cnt cleared, irq retained.
